// File: rtl/voice_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voice_sched_pkg
// Purpose  : Shared types, widths and RAM word helpers for the voice phase
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package voice_sched_pkg;

    localparam int c_NUM_VOICES = 16;
    localparam int c_VOICE_W    = 4;
    localparam int c_PHASE_W    = 24;
    localparam int c_INC_W      = 24;
    localparam int DATA_W       = c_INC_W + c_PHASE_W;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // RAM word layout: increment in the upper half, phase in the lower half.
    function automatic logic [DATA_W-1:0] pack_word(input logic [c_INC_W-1:0]   inc,
                                                    input logic [c_PHASE_W-1:0] phase);
        return {inc, phase};
    endfunction

    function automatic logic [c_INC_W-1:0] unpack_inc(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: c_INC_W];
    endfunction

    function automatic logic [c_PHASE_W-1:0] unpack_phase(input logic [DATA_W-1:0] word);
        return word[c_PHASE_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_phase_sched.sv
`default_nettype none
// ============================================================================
// Module   : voice_phase_sched
// Purpose  : Sweeps the per-voice phase RAM on each sample tick (read A,
//            add increment, write back B) and arbitrates host note writes.
// Revision : 1.0 - initial release
// ============================================================================
module voice_phase_sched
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES = c_NUM_VOICES,
    parameter int VOICE_W    = c_VOICE_W,
    parameter int PHASE_W    = c_PHASE_W,
    parameter int INC_W      = c_INC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_tick,
    input  logic                     host_req,
    input  logic [VOICE_W-1:0]       host_voice,
    input  logic [INC_W-1:0]         host_inc,
    output logic                     host_ack,
    output logic [VOICE_W-1:0]       addra,
    output logic                     write_ena,
    output logic [INC_W+PHASE_W-1:0] dina,
    input  logic [INC_W+PHASE_W-1:0] douta,
    output logic [VOICE_W-1:0]       addrb,
    output logic                     write_enb,
    output logic [INC_W+PHASE_W-1:0] dinb,
    output logic [PHASE_W-1:0]       phase_out,
    output logic [VOICE_W-1:0]       phase_voice,
    output logic                     phase_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [VOICE_W-1:0] c_LAST = VOICE_W'(NUM_VOICES - 1);
    localparam logic [VOICE_W-1:0] c_ONE  = VOICE_W'(1);

    state_e               r_state;
    logic [VOICE_W-1:0]   r_ptr;
    logic [VOICE_W-1:0]   r_rd_ptr;
    logic [VOICE_W-1:0]   r_wb_voice;
    logic                 r_wb_vld;
    logic [PHASE_W-1:0]   r_phase_out;
    logic [VOICE_W-1:0]   r_phase_voice;
    logic                 r_phase_valid;
    logic                 r_overrun;

    logic                 w_host_grant;
    logic [PHASE_W-1:0]   w_next_phase;

    // Host writes only in IDLE, so port B never targets the address port A reads.
    assign w_host_grant = !rst && (r_state == ST_IDLE) && host_req && !sample_tick;
    assign w_next_phase = unpack_phase(douta) + unpack_inc(douta);

    assign host_ack    = w_host_grant;
    assign addra       = r_rd_ptr;
    assign write_ena   = 1'b0;
    assign dina        = '0;
    assign busy        = (r_state != ST_IDLE);
    assign phase_out   = r_phase_out;
    assign phase_voice = r_phase_voice;
    assign phase_valid = r_phase_valid;
    assign overrun     = r_overrun;

    always_comb begin
        write_enb = 1'b0;
        addrb     = r_wb_voice;
        dinb      = '0;
        if (!rst) begin
            if (r_state == ST_INIT) begin
                write_enb = 1'b1;
                addrb     = r_ptr;
            end else if (r_wb_vld) begin
                write_enb = 1'b1;
                addrb     = r_wb_voice;
                dinb      = pack_word(unpack_inc(douta), w_next_phase);
            end else if (w_host_grant) begin
                write_enb = 1'b1;
                addrb     = host_voice;
                dinb      = pack_word(host_inc, '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_ptr         <= '0;
            r_rd_ptr      <= '0;
            r_wb_voice    <= '0;
            r_wb_vld      <= 1'b0;
            r_phase_out   <= '0;
            r_phase_voice <= '0;
            r_phase_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Writeback trails the read by the RAM's one-cycle latency.
            r_wb_vld      <= (r_state == ST_SWEEP);
            r_wb_voice    <= r_rd_ptr;
            r_phase_valid <= r_wb_vld;
            if (r_wb_vld) begin
                r_phase_out   <= unpack_phase(douta);
                r_phase_voice <= r_wb_voice;
            end
            if (sample_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + c_ONE;
                    if (r_ptr == c_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sample_tick) begin
                        r_state  <= ST_SWEEP;
                        r_rd_ptr <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (r_rd_ptr == c_LAST) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + c_ONE;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_phase_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_phase_sched
// Purpose  : Scoreboard bench for voice_phase_sched with a behavioural
//            dual-port RAM (one-cycle registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_phase_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic        host_req = 1'b0;
    logic [3:0]  host_voice = '0;
    logic [23:0] host_inc = '0;
    logic        host_ack;
    logic [3:0]  addra;
    logic        write_ena;
    logic [47:0] dina;
    logic [47:0] douta;
    logic [3:0]  addrb;
    logic        write_enb;
    logic [47:0] dinb;
    logic [23:0] phase_out;
    logic [3:0]  phase_voice;
    logic        phase_valid;
    logic        busy;
    logic        overrun;

    logic [47:0] mem [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [47:0] bd_data = '0;

    logic [23:0] exp_inc [16];
    logic [23:0] exp_ph  [16];
    logic [27:0] sb [$];

    int checks = 0;
    int errors = 0;

    voice_phase_sched #(
        .NUM_VOICES(16),
        .VOICE_W   (4),
        .PHASE_W   (24),
        .INC_W     (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .host_req   (host_req),
        .host_voice (host_voice),
        .host_inc   (host_inc),
        .host_ack   (host_ack),
        .addra      (addra),
        .write_ena  (write_ena),
        .dina       (dina),
        .douta      (douta),
        .addrb      (addrb),
        .write_enb  (write_enb),
        .dinb       (dinb),
        .phase_out  (phase_out),
        .phase_voice(phase_voice),
        .phase_valid(phase_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        douta <= mem[addra];
        if (write_ena) mem[addra] <= dina;
        if (write_enb) mem[addrb] <= dinb;
        if (bd_we)     mem[bd_addr] <= bd_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && phase_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got voice %0h phase %0h expected none", phase_voice, phase_out);
            end else begin
                logic [27:0] e;
                e = sb.pop_front();
                chk("beat_voice", 64'(phase_voice), 64'(e[27:24]));
                chk("beat_phase", 64'(phase_out), 64'(e[23:0]));
            end
        end
    end

    // Entered at the start of the first INIT cycle after rst falls.
    task automatic check_init();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_we", 64'(write_enb), 64'd1);
            chk("init_addrb", 64'(addrb), 64'(i));
            chk("init_dinb", 64'(dinb), 64'd0);
            chk("init_busy", 64'(busy), 64'd1);
            chk("init_no_ack", 64'(host_ack), 64'd0);
            chk("init_valid", 64'(phase_valid), 64'd0);
            if (i == 0) begin
                chk("init_phase_out", 64'(phase_out), 64'd0);
                chk("init_phase_voice", 64'(phase_voice), 64'd0);
                chk("init_overrun", 64'(overrun), 64'd0);
            end
            step();
        end
        for (int v = 0; v < 16; v++) begin
            exp_inc[v] = '0;
            exp_ph[v]  = '0;
        end
    endtask

    // Pulses the tick in cycle t0 and returns at the start of t0+1.
    task automatic start_sweep();
        for (int v = 0; v < 16; v++) begin
            sb.push_back({4'(v), exp_ph[v]});
            exp_ph[v] = exp_ph[v] + exp_inc[v];
        end
        sample_tick = 1'b1;
        @(negedge clk);
        chk("t0_busy", 64'(busy), 64'd0);
        chk("t0_no_ack", 64'(host_ack), 64'd0);
        step();
        sample_tick = 1'b0;
    endtask

    // Walks t0+1..t0+18; extra>0 injects a second tick in that cycle.
    task automatic sweep_timing(input int extra);
        for (int n = 1; n <= 18; n++) begin
            if (n == extra) sample_tick = 1'b1;
            @(negedge clk);
            chk("sweep_busy", 64'(busy), 64'(n <= 17));
            chk("sweep_valid", 64'(phase_valid), 64'(n >= 3));
            chk("sweep_ack", 64'(host_ack), 64'((n == 18) && host_req));
            chk("sweep_web", 64'(write_enb), 64'(((n >= 2) && (n <= 17)) || ((n == 18) && host_req)));
            if (n <= 16) chk("sweep_addra", 64'(addra), 64'(n - 1));
            if ((n >= 2) && (n <= 17)) chk("sweep_addrb", 64'(addrb), 64'(n - 2));
            step();
            sample_tick = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_valid", 64'(phase_valid), 64'd0);
        chk("rst_phase_out", 64'(phase_out), 64'd0);
        chk("rst_phase_voice", 64'(phase_voice), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_ack", 64'(host_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_web", 64'(write_enb), 64'd0);
        step();
        step();
        rst        = 1'b0;
        host_req   = 1'b1;
        host_voice = 4'd3;
        host_inc   = 24'h000100;
        check_init();

        // Held host request is granted in the first IDLE cycle.
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("host_ack", 64'(host_ack), 64'd1);
        chk("host_addrb", 64'(addrb), 64'd3);
        chk("host_dinb", 64'(dinb), 64'h000100_000000);
        step();
        host_req   = 1'b0;
        exp_inc[3] = 24'h000100;
        exp_ph[3]  = 24'h0;
        @(negedge clk);
        chk("ram_v3_host", 64'(mem[3]), 64'h000100_000000);
        chk("ack_drop", 64'(host_ack), 64'd0);
        chk("wea_zero", 64'(write_ena), 64'd0);
        step();

        start_sweep();
        sweep_timing(0);
        chk("ram_v3_sweep1", 64'(mem[3]), 64'h000100_000100);
        chk("ram_v0_sweep1", 64'(mem[0]), 64'h0);

        start_sweep();
        sweep_timing(0);
        chk("ram_v3_sweep2", 64'(mem[3]), 64'h000100_000200);

        bd_we   = 1'b1;
        bd_addr = 4'd5;
        bd_data = 48'h800000_C00000;
        step();
        bd_we      = 1'b0;
        exp_inc[5] = 24'h800000;
        exp_ph[5]  = 24'hC00000;
        start_sweep();
        sweep_timing(0);
        chk("ram_v5_wrap", 64'(mem[5]), 64'h800000_400000);

        // Tick and host request together, plus an overrun tick mid-sweep.
        chk("overrun_pre", 64'(overrun), 64'd0);
        host_req   = 1'b1;
        host_voice = 4'd9;
        host_inc   = 24'h000010;
        start_sweep();
        sweep_timing(5);
        host_req   = 1'b0;
        exp_inc[9] = 24'h000010;
        exp_ph[9]  = 24'h0;
        chk("ram_v9_host", 64'(mem[9]), 64'h000010_000000);
        chk("overrun_set", 64'(overrun), 64'd1);

        start_sweep();
        sweep_timing(0);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        chk("ram_v9_sweep", 64'(mem[9]), 64'h000010_000010);

        // Reset asserted during cycle t0+8.
        start_sweep();
        repeat (7) step();
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        sb.delete();
        check_init();
        chk("overrun_cleared", 64'(overrun), 64'd0);
        for (int v = 0; v < 16; v++) begin
            chk("ram_cleared", 64'(mem[v]), 64'h0);
        end

        start_sweep();
        sweep_timing(0);
        repeat (3) step();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/voice_phase_sched.md
Name: voice_phase_sched

Overview:
- Sequencer for the per-voice phase-accumulator RAM, a true dual-port block RAM with a registered read and one-cycle read latency.
- On each sample tick it sweeps all voices: read on port A, add the increment, write back on port B. It streams each voice's pre-update phase to the oscillator stage.
- It shares port B between the sweep writebacks and MIDI note-on/off writes from the host.
- After reset it clears the RAM before accepting any work.

Parameters:
- NUM_VOICES, 16, number of voices; must be a power of two.
- VOICE_W, 4, voice index and RAM address width; equals log2(NUM_VOICES).
- PHASE_W, 24, phase accumulator width.
- INC_W, 24, phase increment width.
- RAM word: DATA_W = INC_W+PHASE_W. Packing is {inc[INC_W-1:0], phase[PHASE_W-1:0]}.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse that starts a sweep.
- host_req  in  1  host write request; held until host_ack.
- host_voice  in  VOICE_W  target voice; stable while host_req=1.
- host_inc  in  INC_W  new increment (0 = voice off); stable while host_req=1.
- host_ack  out  1  one-cycle pulse in the cycle the host write is issued.
- addra  out  VOICE_W  RAM port A address (read only).
- write_ena  out  1  RAM port A write enable; tied 0.
- dina  out  DATA_W  RAM port A write data; tied 0.
- douta  in  DATA_W  RAM port A read data, valid one cycle after addra.
- addrb  out  VOICE_W  RAM port B address.
- write_enb  out  1  RAM port B write enable.
- dinb  out  DATA_W  RAM port B write data.
- phase_out  out  PHASE_W  pre-update phase of phase_voice.
- phase_voice  out  VOICE_W  voice index for phase_out.
- phase_valid  out  1  phase_out/phase_voice qualifier.
- busy  out  1  high in INIT, SWEEP and DRAIN.
- overrun  out  1  sticky: a tick arrived while not IDLE.

Behaviour:
- States:
  - INIT, IDLE, SWEEP, DRAIN.
  - rst forces INIT with ptr=0 and sets all registered outputs to 0: phase_out, phase_voice, phase_valid, overrun, host_ack.
  - rst mid-sweep abandons the sweep immediately; partially written voices keep their new values until the INIT clear.
- INIT:
  - Each cycle drives write_enb=1, addrb=ptr, dinb=0, then ptr++.
  - After the write to NUM_VOICES-1, goes to IDLE.
  - The first cycle after rst falls writes address 0; INIT lasts NUM_VOICES cycles.
  - host_req is ignored and no ack is given.
- IDLE:
  - sample_tick=1 goes to SWEEP with rd_ptr=0.
  - Tick has priority over the host: a simultaneous host_req waits.
  - Otherwise, if host_req=1: write_enb=1, addrb=host_voice, dinb={host_inc, PHASE_W'0}, and host_ack=1 in the same cycle (combinational). Note-on therefore resets phase.
  - Host writes are granted only in IDLE. This excludes a cross-port read/write collision on the same address, which the RAM does not check.
- SWEEP, cycle-level, with the tick seen in IDLE at cycle t0:
  - Reads: addra=rd_ptr=k during cycles t0+1..t0+NUM_VOICES.
  - Writeback for voice k in the following cycle: write_enb=1, addrb=k (delayed rd_ptr), dinb={inc, phase+inc mod 2^PHASE_W}, computed from douta. Increment overflow wraps silently.
  - When rd_ptr=NUM_VOICES-1 has been read, goes to DRAIN for the final writeback (cycle t0+NUM_VOICES+1).
  - DRAIN goes to IDLE at t0+NUM_VOICES+2.
- phase_out/phase_voice/phase_valid:
  - Registered from the writeback cycle, so they are valid during t0+3..t0+NUM_VOICES+2.
  - One beat per voice in ascending order; no backpressure.
- Port A: addra holds its last value outside SWEEP (don't-care data); write_ena=0 always.
- Port B: write_enb=0 whenever no INIT, writeback or host write is active.
- overrun: sample_tick in INIT, SWEEP or DRAIN sets it (sticky until rst); the tick is dropped.
- busy: registered state decode; high from t0+1 through t0+NUM_VOICES+1.

Decomposition:
- Package voice_sched_pkg:
  - state enum (INIT, IDLE, SWEEP, DRAIN);
  - DATA_W localparam;
  - pack_word and unpack_inc/unpack_phase functions.
- No sub-module. The RAM instance lives in the parent and connects port-for-port to the addra/dina/write_ena/douta and addrb/dinb/write_enb ports.
- The bench uses a behavioural dual-port RAM with one-cycle registered read.

Test Plan:
- Reset release: rst high 3 cycles, then low -> write_enb=1 for 16 cycles, addrb 0..15, dinb=0, busy=1; IDLE on cycle 17; host_req during INIT gets no ack.
- Host write then sweep: voice 3 inc=0x000100 acked in IDLE -> word {0x000100,0}; tick -> voice 3 emits phase_out=0, RAM becomes 0x000100. Second tick -> phase_out=0x000100, RAM becomes 0x000200. Other voices emit 0.
- Wrap: voice 5 with inc=0x800000 and phase=0xC00000 -> writeback phase 0x400000, inc unchanged, phase_out=0xC00000.
- Sweep timing: tick at t0 -> phase_valid high exactly t0+3..t0+18, phase_voice 0..15 in order, busy t0+1..t0+17, IDLE at t0+18.
- Tick/host collision: tick and host_req in the same IDLE cycle -> sweep starts, no ack; ack occurs at t0+18 and the host value lands after the sweep. Tick during sweep -> overrun=1, stays 1 until rst.
- Reset mid-sweep: rst at t0+8 -> next cycle all outputs 0, state INIT; full 16-cycle zero clear follows.
